// File: rtl/instruction_input_arbiter.sv
// ---------------------------------------------------------------------------
// instruction_input_arbiter
//   Shares one instruction-input consumer port between N_REQ producers.
//   The move channel and the immediate channel are arbitrated independently,
//   each by an iia_chan instance: round-robin winner selection feeding a
//   one-entry registered output stage (one transfer per cycle per channel).
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   req_move_from/_valid   per-producer move source (producer i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   req_move_ack           move accepted from producer i this cycle (one-hot or 0)
//   req_immediate/_valid   per-producer immediate (producer i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_immediate_ack      immediate accepted from producer i this cycle (one-hot or 0)
//   out_move_from/_valid   registered move to the consumer, out_move_ack accepts it
//   out_immediate/_valid   registered immediate to the consumer, out_immediate_ack accepts it
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// iia_chan
//   One arbitrated channel: round-robin pointer, winner scan and a one-entry
//   hold register whose contents drive the consumer directly.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   i_req_data    packed producer data, producer i at [i*W +: W]
//   i_req_valid   producer request valids
//   o_req_ack     one-hot accept towards the winning producer
//   o_data        registered data to the consumer
//   o_valid       registered valid to the consumer
//   i_ack         consumer accept
// ---------------------------------------------------------------------------
module iia_chan #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ*W-1:0]   i_req_data,
    input  logic [N_REQ-1:0]     i_req_valid,
    output logic [N_REQ-1:0]     o_req_ack,
    output logic [W-1:0]         o_data,
    output logic                 o_valid,
    input  logic                 i_ack
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_hold_data;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  w_win;
    logic [PW-1:0]  w_ptr_nxt;
    logic           w_any;
    logic           w_can_load;
    logic           w_load;

    // Scan from the highest offset down so the lowest offset from r_ptr
    // (the first producer in round-robin order) is the last one written.
    always_comb begin
        int idx;
        idx   = 0;
        w_win = '0;
        w_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (i_req_valid[idx]) begin
                w_win = PW'(idx);
                w_any = 1'b1;
            end
        end
    end

    // Drain and reload share an edge when FULL and the consumer accepts.
    assign w_can_load = (r_state == EMPTY) || i_ack;
    assign w_load     = w_can_load && w_any;
    assign w_ptr_nxt  = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        o_req_ack = '0;
        if (w_load && !rst) o_req_ack[w_win] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load)
            w_state_nxt = FULL;
        else if (r_state == FULL && i_ack)
            w_state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Data holds its value on a pure drain; only a load replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_data <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_hold_data <= i_req_data[w_win*W +: W];
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign o_data  = r_hold_data;
    assign o_valid = (r_state == FULL);
endmodule

module instruction_input_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  req_move_from,
    input  logic [N_REQ-1:0]             req_move_valid,
    output logic [N_REQ-1:0]             req_move_ack,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_immediate,
    input  logic [N_REQ-1:0]             req_immediate_valid,
    output logic [N_REQ-1:0]             req_immediate_ack,
    output logic [ADDR_WIDTH-1:0]        out_move_from,
    output logic                         out_move_valid,
    input  logic                         out_move_ack,
    output logic [DATA_WIDTH-1:0]        out_immediate,
    output logic                         out_immediate_valid,
    input  logic                         out_immediate_ack
);
    iia_chan #(.N_REQ(N_REQ), .W(ADDR_WIDTH)) u_move (
        .clk         (clk),
        .rst         (rst),
        .i_req_data  (req_move_from),
        .i_req_valid (req_move_valid),
        .o_req_ack   (req_move_ack),
        .o_data      (out_move_from),
        .o_valid     (out_move_valid),
        .i_ack       (out_move_ack)
    );

    iia_chan #(.N_REQ(N_REQ), .W(DATA_WIDTH)) u_imm (
        .clk         (clk),
        .rst         (rst),
        .i_req_data  (req_immediate),
        .i_req_valid (req_immediate_valid),
        .o_req_ack   (req_immediate_ack),
        .o_data      (out_immediate),
        .o_valid     (out_immediate_valid),
        .i_ack       (out_immediate_ack)
    );
endmodule

// File: tb/tb_instruction_input_arbiter.sv
module tb_instruction_input_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] req_move_from;
    logic [N-1:0]    req_move_valid;
    logic [N-1:0]    req_move_ack;
    logic [N*DW-1:0] req_immediate;
    logic [N-1:0]    req_immediate_valid;
    logic [N-1:0]    req_immediate_ack;
    logic [AW-1:0]   out_move_from;
    logic            out_move_valid;
    logic            out_move_ack;
    logic [DW-1:0]   out_immediate;
    logic            out_immediate_valid;
    logic            out_immediate_ack;

    instruction_input_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_move_from       (req_move_from),
        .req_move_valid      (req_move_valid),
        .req_move_ack        (req_move_ack),
        .req_immediate       (req_immediate),
        .req_immediate_valid (req_immediate_valid),
        .req_immediate_ack   (req_immediate_ack),
        .out_move_from       (out_move_from),
        .out_move_valid      (out_move_valid),
        .out_move_ack        (out_move_ack),
        .out_immediate       (out_immediate),
        .out_immediate_valid (out_immediate_valid),
        .out_immediate_ack   (out_immediate_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: channel 0 = move, 1 = immediate.
    logic          m_hv [2];
    logic [DW-1:0] m_hd [2];
    int            m_ptr[2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_hv[c]  = 1'b0;
            m_hd[c]  = '0;
            m_ptr[c] = 0;
        end
    endfunction

    // First requesting producer in round-robin order from ptr, or -1.
    function automatic int model_win(input int ch, input logic [N-1:0] v, input logic oack);
        if (m_hv[ch] && !oack) return -1;
        for (int k = 0; k < N; k++)
            if (v[(m_ptr[ch] + k) % N]) return (m_ptr[ch] + k) % N;
        return -1;
    endfunction

    // Called just after a falling edge with inputs settled: check outputs
    // against the model, advance one rising edge, return the model's acks.
    task automatic step(input string tag, output logic [N-1:0] am, output logic [N-1:0] ai);
        int wm, wi;
        #1;
        chk({tag, ".mv"}, 64'(out_move_valid), 64'(m_hv[0]));
        chk({tag, ".md"}, 64'(out_move_from), 64'(m_hd[0]));
        chk({tag, ".iv"}, 64'(out_immediate_valid), 64'(m_hv[1]));
        chk({tag, ".id"}, 64'(out_immediate), 64'(m_hd[1]));
        wm = model_win(0, req_move_valid, out_move_ack);
        wi = model_win(1, req_immediate_valid, out_immediate_ack);
        am = '0; ai = '0;
        if (wm >= 0) am[wm] = 1'b1;
        if (wi >= 0) ai[wi] = 1'b1;
        chk({tag, ".mack"}, 64'(req_move_ack), 64'(am));
        chk({tag, ".iack"}, 64'(req_immediate_ack), 64'(ai));
        if (wm >= 0) begin
            m_hd[0] = DW'(req_move_from[wm*AW +: AW]); m_hv[0] = 1'b1; m_ptr[0] = (wm + 1) % N;
        end else if (out_move_ack && m_hv[0]) m_hv[0] = 1'b0;
        if (wi >= 0) begin
            m_hd[1] = req_immediate[wi*DW +: DW]; m_hv[1] = 1'b1; m_ptr[1] = (wi + 1) % N;
        end else if (out_immediate_ack && m_hv[1]) m_hv[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for an edge.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, ".mv"}, 64'(out_move_valid), 64'd0);
        chk({tag, ".md"}, 64'(out_move_from), 64'd0);
        chk({tag, ".iv"}, 64'(out_immediate_valid), 64'd0);
        chk({tag, ".id"}, 64'(out_immediate), 64'd0);
        chk({tag, ".mack"}, 64'(req_move_ack), 64'd0);
        chk({tag, ".iack"}, 64'(req_immediate_ack), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [N-1:0] am, ai;

    initial begin
        rst = 1'b0;
        req_move_from = '0; req_move_valid = '0; out_move_ack = 1'b0;
        req_immediate = '0; req_immediate_valid = '0; out_immediate_ack = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with requests present: acks must stay 0.
        req_move_valid = 4'b1111; req_immediate_valid = 4'b1111;
        out_move_ack = 1'b1; out_immediate_ack = 1'b1;
        mid_reset("rst0");

        // Idle.
        req_move_valid = '0; req_immediate_valid = '0;
        for (int c = 0; c < 5; c++) begin
            out_move_ack = 1'($urandom); out_immediate_ack = 1'($urandom);
            step("idle", am, ai);
        end

        // Single request from producer 2.
        req_move_from[2*AW +: AW] = 8'h5A; req_move_valid = 4'b0100; out_move_ack = 1'b1;
        #1 chk("single.ack", 64'(req_move_ack), 64'b0100);
        step("single", am, ai);
        req_move_valid = '0;
        #1 chk("single.out", 64'({out_move_valid, out_move_from}), 64'h15A);
        chk("single.imm", 64'(out_immediate_valid), 64'd0);
        // Move ptr is now 3: producers 0 and 3 both request, 3 must win.
        req_move_from[0 +: AW] = 8'h10; req_move_from[3*AW +: AW] = 8'h13;
        req_move_valid = 4'b1001;
        #1 chk("single.ptr3", 64'(req_move_ack), 64'b1000);
        step("ptr3", am, ai);
        req_move_valid = '0;
        step("drain", am, ai);

        // Round robin on immediates.
        for (int i = 0; i < N; i++) req_immediate[i*DW +: DW] = 32'h100 + i;
        req_immediate_valid = 4'b1111; out_immediate_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 chk("rr.ack", 64'(req_immediate_ack), 64'(1 << (c % N)));
            if (c > 0) chk("rr.out", 64'(out_immediate), 64'(32'h100 + ((c - 1) % N)));
            step("rr", am, ai);
        end
        req_immediate_valid = '0;
        step("rr.end", am, ai);

        // Backpressure on move. Ptr is 0 after the earlier producer-3 grant.
        req_move_from[0 +: AW] = 8'h11; req_move_valid = 4'b0001; out_move_ack = 1'b0;
        step("bp.fill", am, ai);
        req_move_from[1*AW +: AW] = 8'h21; req_move_from[3*AW +: AW] = 8'h23;
        req_move_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp.noack", 64'(req_move_ack), 64'd0);
            chk("bp.hold", 64'({out_move_valid, out_move_from}), 64'h111);
            step("bp", am, ai);
        end
        out_move_ack = 1'b1;
        #1 chk("bp.p1", 64'(req_move_ack), 64'b0010);
        step("bp.p1", am, ai);
        req_move_valid = 4'b1000;
        #1 chk("bp.p3", 64'(req_move_ack), 64'b1000);
        chk("bp.out1", 64'(out_move_from), 64'h21);
        step("bp.p3", am, ai);
        req_move_valid = '0;

        // Channel independence: move stuck full, immediates stream.
        out_move_ack = 1'b0;
        req_immediate_valid = 4'b0011; out_immediate_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk("ind.mv", 64'({out_move_valid, out_move_from}), 64'h123);
            chk("ind.istream", 64'(|req_immediate_ack), 64'd1);
            step("ind", am, ai);
        end
        req_immediate_valid = '0;

        // Randomized traffic with hold-until-ack producers and occasional withdrawal.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (am[i] || !req_move_valid[i]) begin
                    req_move_valid[i] = ($urandom_range(2) != 0);
                    req_move_from[i*AW +: AW] = AW'($urandom);
                end else if ($urandom_range(15) == 0) req_move_valid[i] = 1'b0;
                if (ai[i] || !req_immediate_valid[i]) begin
                    req_immediate_valid[i] = ($urandom_range(2) != 0);
                    req_immediate[i*DW +: DW] = $urandom;
                end else if ($urandom_range(15) == 0) req_immediate_valid[i] = 1'b0;
            end
            out_move_ack = ($urandom_range(3) != 0);
            out_immediate_ack = ($urandom_range(3) != 0);
            step("rnd", am, ai);
        end

        // Reset mid-stream with move FULL and ptr=2.
        req_move_valid = '0; req_immediate_valid = '0;
        mid_reset("rst1");
        req_move_from[1*AW +: AW] = 8'h31; req_move_valid = 4'b0010; out_move_ack = 1'b0;
        step("rst.fill", am, ai);
        req_move_valid = '0;
        mid_reset("rst2");
        req_move_from[0 +: AW] = 8'h40; req_move_from[2*AW +: AW] = 8'h42;
        req_move_valid = 4'b0101; out_move_ack = 1'b1;
        #1 chk("rst.p0first", 64'(req_move_ack), 64'b0001);
        step("rst.p0", am, ai);
        req_move_valid = 4'b0100;
        step("rst.p2", am, ai);
        req_move_valid = '0;
        step("rst.end", am, ai);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1);
    end
endmodule

// File: doc/instruction_input_arbiter.md
# instruction_input_arbiter

Round-robin arbiter that shares one instruction-input consumer port (move channel plus immediate channel) between `N_REQ` producers. The two channels are arbitrated independently. Each channel has a one-entry registered output stage, so the consumer sees registered valid/data and sustains one transfer per cycle per channel. It sits between the instruction sources (fetch/decode units, debug injector) and the single instruction-input consumer of the processing element.

## Interface
- `N_REQ`, 4: number of producers, 2..8.
- `ADDR_WIDTH`, 8: width of `move_from`.
- `DATA_WIDTH`, 32: width of `immediate`.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_move_from` in N_REQ*ADDR_WIDTH: producer i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_move_valid` in N_REQ: producer move requests.
- `req_move_ack` out N_REQ: move accepted from producer i this cycle.
- `req_immediate` in N_REQ*DATA_WIDTH: producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_immediate_valid` in N_REQ: producer immediate requests.
- `req_immediate_ack` out N_REQ: immediate accepted from producer i this cycle.
- `out_move_from` out ADDR_WIDTH: registered move source to the consumer.
- `out_move_valid` out 1: registered move valid.
- `out_move_ack` in 1: consumer accepts the move.
- `out_immediate` out DATA_WIDTH: registered immediate to the consumer.
- `out_immediate_valid` out 1: registered immediate valid.
- `out_immediate_ack` in 1: consumer accepts the immediate.

## Operation
- Handshake on every port: a transfer occurs on a rising edge where valid && ack.
  - A producer holds valid and data stable until acked.
  - Ack is meaningless while valid=0 and is ignored.
- Each channel (move, immediate) holds identical, fully independent logic:
  - a one-entry register `hold_data` / `hold_valid`;
  - a round-robin pointer `ptr` (clog2(N_REQ) bits).
- State per channel: EMPTY (`hold_valid`=0) or FULL (`hold_valid`=1).
- `can_load` = EMPTY || (FULL && out ack).
- Winner selection:
  - Winner = first i with req valid[i], scanning ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - `req_*_ack[winner]` = `can_load` && any valid. All other acks are 0.
  - At most one ack bit is set per channel per cycle.
- Req acks are combinational from `hold_valid`, out ack, `ptr` and req valids. They have no combinational path from req data.
- On a load edge:
  - `hold_data` ← winner's data and `hold_valid` ← 1;
  - `ptr` ← (winner+1) mod N_REQ.
- On an edge with out ack && FULL && no load: `hold_valid` ← 0, and `hold_data` holds its value.
- With no requests, `ptr` is unchanged.
- `out_*` = `hold_*` directly (registered). Data is stable while valid && !ack.
- No ordering or pairing is enforced between the move and immediate channels. Producers and the consumer pair them by order of transfer.

## Timing
- Reset (asynchronous assert, synchronous release): `out_move_valid`=0, `out_immediate_valid`=0, `out_move_from`=0, `out_immediate`=0, both `ptr`=0. Req acks are 0 while `rst`=1.
- Latency: a request acked at edge N appears on out at cycle N+1. Minimum latency is 1 cycle.
- Throughput: 1 transfer/cycle/channel, because drain and load happen on the same edge when FULL && out ack.
- Backpressure: when FULL and out ack=0, all req acks are 0 and `ptr` is frozen.
- Fairness: with all N_REQ continuously requesting, grants rotate 0,1,…,N_REQ-1,0. The worst-case wait is N_REQ-1 grants.
- `ptr` wrap: after granting N_REQ-1, `ptr`=0.
- Reset mid-operation: any held entry is dropped without transfer and arbitration restarts at producer 0. Producers re-present un-acked requests.
- A req valid deasserting without ack is tolerated; that producer simply is not selected.

## Test plan
- Reset/idle:
  - Assert `rst` mid-cycle -> outputs go to 0 immediately.
  - Release, all valids 0 for 5 cycles -> no acks, out valids 0.
- Single request:
  - Producer 2 drives move_from=0x5A with out_move_ack=1 -> `req_move_ack`=4'b0100 in the same cycle.
  - Next cycle `out_move_from`=0x5A, `out_move_valid`=1.
  - Move `ptr`=3; immediate channel untouched.
- Round robin:
  - All 4 producers continuously request immediates 0x100+i, out ack=1.
  - Grant order 0,1,2,3,0,1; out sequence 0x100,0x101,0x102,0x103,0x100; one transfer per cycle.
- Backpressure:
  - Hold FULL with `out_move_ack`=0 for 3 cycles while producers 1 and 3 request -> no req acks, out data stable.
  - Ack -> same-edge load of producer 1 (`ptr`=1), then producer 3.
- Channel independence:
  - Move ack held 0 while the immediate channel streams from producers 0,1 -> immediate transfers continue every cycle.
  - `out_move_valid` stays 1 with its original data.
- Reset mid-stream:
  - Assert `rst` while FULL with `ptr`=2 -> held entry lost, `ptr`=0.
  - After release, producers 0 and 2 requesting -> producer 0 granted first.
